// File: rtl/round_key_arbiter.sv
// Round-key arbiter: shares one key scheduler between encryptor and
// decryptor with round-robin ownership and a 2-stage read pipeline.
module round_key_arbiter #(
   parameter int unsigned KEY_W   = 128,
   parameter int unsigned SEL_W   = 4,
   parameter int unsigned LAST_RK = 10
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             NewKey,
   output logic             KeyEn,
   input  logic             KeyRy,
   output logic [SEL_W-1:0] SchedSelKey,
   input  logic [KEY_W-1:0] SchedKey,
   input  logic             EncReq,
   input  logic             DecReq,
   output logic             EncGnt,
   output logic             DecGnt,
   input  logic             EncRdEn,
   input  logic [SEL_W-1:0] EncSelKey,
   input  logic             DecRdEn,
   input  logic [SEL_W-1:0] DecSelKey,
   output logic [KEY_W-1:0] RdKey,
   output logic             EncRdVld,
   output logic             DecRdVld,
   output logic             Err
);

   typedef enum logic [2:0] {
      EXPAND,
      WAIT_KEY,
      IDLE,
      GNT_ENC,
      GNT_DEC
   } state_t;

   state_t             state_q, state_d;
   logic               rr_q, rr_d;
   logic               nk_q, nk_d;
   logic               key_en_q, key_en_d;
   logic               s1_vld_q, s1_vld_d;
   logic               s1_enc_q, s1_enc_d;
   logic               s1_bad_q, s1_bad_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic               enc_vld_q, enc_vld_d;
   logic               dec_vld_q, dec_vld_d;
   logic               err_q, err_d;

   logic               pipe_empty;
   logic               rd_go;
   logic               rd_enc;
   logic [SEL_W-1:0]   rd_sel;
   logic               rd_bad;

   assign pipe_empty = !s1_vld_q && !enc_vld_q && !dec_vld_q;

   // Next state: expansion handshake, round-robin grant, NewKey latch.
   // KeyRy is ignored while KeyEn is still high so a stale ready level
   // from the previous expansion cannot end the wait early.
   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      nk_d    = nk_q | NewKey;
      case (state_q)
         EXPAND: begin
            state_d = WAIT_KEY;
            nk_d    = 1'b0;
         end
         WAIT_KEY: begin
            if (KeyRy && !key_en_q) state_d = IDLE;
         end
         IDLE: begin
            if (nk_q || NewKey) begin
               if (pipe_empty) begin
                  state_d = EXPAND;
                  nk_d    = 1'b0;
               end
            end else if (EncReq && (!DecReq || !rr_q)) begin
               state_d = GNT_ENC;
               rr_d    = 1'b1;
            end else if (DecReq) begin
               state_d = GNT_DEC;
               rr_d    = 1'b0;
            end
         end
         GNT_ENC: begin
            if (!EncReq) state_d = IDLE;
         end
         GNT_DEC: begin
            if (!DecReq) state_d = IDLE;
         end
         default: state_d = EXPAND;
      endcase
   end

   // Read pipeline: stage 1 drives the scheduler index, stage 2 captures
   // the returned key. Out-of-range indices keep the old index.
   always_comb begin
      rd_enc    = (state_q == GNT_ENC);
      rd_go     = (rd_enc && EncRdEn) ||
                  ((state_q == GNT_DEC) && DecRdEn);
      rd_sel    = rd_enc ? EncSelKey : DecSelKey;
      rd_bad    = (32'(rd_sel) > LAST_RK);
      key_en_d  = (state_q == EXPAND);
      s1_vld_d  = rd_go;
      s1_enc_d  = rd_enc;
      s1_bad_d  = rd_bad;
      sel_d     = (rd_go && !rd_bad) ? rd_sel : sel_q;
      key_d     = key_q;
      if (s1_vld_q) key_d = s1_bad_q ? '0 : SchedKey;
      enc_vld_d = s1_vld_q && s1_enc_q;
      dec_vld_d = s1_vld_q && !s1_enc_q;
      err_d     = err_q || (s1_vld_q && s1_bad_q);
   end

   // State and pipeline registers, all cleared by the async reset.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q   <= EXPAND;
         rr_q      <= 1'b0;
         nk_q      <= 1'b0;
         key_en_q  <= 1'b0;
         s1_vld_q  <= 1'b0;
         s1_enc_q  <= 1'b0;
         s1_bad_q  <= 1'b0;
         sel_q     <= '0;
         key_q     <= '0;
         enc_vld_q <= 1'b0;
         dec_vld_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         nk_q      <= nk_d;
         key_en_q  <= key_en_d;
         s1_vld_q  <= s1_vld_d;
         s1_enc_q  <= s1_enc_d;
         s1_bad_q  <= s1_bad_d;
         sel_q     <= sel_d;
         key_q     <= key_d;
         enc_vld_q <= enc_vld_d;
         dec_vld_q <= dec_vld_d;
         err_q     <= err_d;
      end
   end

   assign KeyEn       = key_en_q;
   assign EncGnt      = (state_q == GNT_ENC);
   assign DecGnt      = (state_q == GNT_DEC);
   assign SchedSelKey = sel_q;
   assign RdKey       = key_q;
   assign EncRdVld    = enc_vld_q;
   assign DecRdVld    = dec_vld_q;
   assign Err         = err_q;

endmodule
